// File: rtl/jk_counter_pkg.sv
// Shared definitions for the JK counter slice.
// Holds the JK command encoding used by the excitation logic and the
// storage cells, plus the nominal gate-level timing budget figures.
package jk_counter_pkg;

   // JK command encoding, packed as {j, k}
   typedef enum logic [1:0] {
      JK_HOLD   = 2'b00,
      JK_RESET  = 2'b01,
      JK_SET    = 2'b10,
      JK_TOGGLE = 2'b11
   } jk_cmd_e;

   // Nominal gate delay (ps) and the extra levels beyond the AND chain
   // that the excitation path is budgeted for (wrap compare + mux).
   localparam int unsigned GATE_DELAY_PS    = 100;
   localparam int unsigned EXCITE_EXTRA_LVL = 4;

   // Excitation levels for a counter of the given width
   function automatic int unsigned excite_levels(input int unsigned width);
      return width + EXCITE_EXTRA_LVL;
   endfunction

endpackage : jk_counter_pkg

// File: rtl/jk_cell.sv
// One JK storage bit with asynchronous active-low clear.
// Ports:
//   clk    - rising-edge clock
//   _reset - asynchronous active-low clear (q -> 0)
//   j, k   - JK excitation inputs
//   q      - stored bit
//   _q     - complement of q
module jk_cell
   import jk_counter_pkg::*;
(
   input  logic clk,
   input  logic _reset,
   input  logic j,
   input  logic k,
   output logic q,
   output logic _q
);

   jk_cmd_e cmd;

   assign cmd = jk_cmd_e'({j, k});

   // JK storage element
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         q <= 1'b0;
      end else begin
         unique case (cmd)
            JK_HOLD:   q <= q;
            JK_RESET:  q <= 1'b0;
            JK_SET:    q <= 1'b1;
            JK_TOGGLE: q <= ~q;
            default:   q <= q;
         endcase
      end
   end

   // Complement derived from q so the pair can never disagree
   assign _q = ~q;

endmodule : jk_cell

// File: rtl/jk_counter.sv
// Modulo up/down counter built from JK storage cells.
// The top level only computes per-bit J/K commands; all state lives in
// the jk_cell bank.
// Ports:
//   clk    - rising-edge clock
//   _reset - asynchronous active-low clear
//   en     - count enable
//   up     - direction (1 = increment, 0 = decrement)
//   load   - synchronous parallel load, overrides en
//   din    - load value (out-of-range values load 0)
//   q      - current count
//   _q     - complement of q
//   tc     - terminal count (combinational), high when the next edge wraps
module jk_counter
   import jk_counter_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 10
) (
   input  logic             clk,
   input  logic             _reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] _q,
   output logic             tc
);

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic [WIDTH-1:0] ones_below;
   logic [WIDTH-1:0] zeros_below;
   logic             at_max;
   logic             at_zero;
   logic             din_ok;

   // Carry/borrow lookahead: bit i toggles when all lower bits are 1 (up)
   // or all lower bits are 0 (down).
   assign ones_below[0]  = 1'b1;
   assign zeros_below[0] = 1'b1;
   for (genvar i = 1; i < WIDTH; i++) begin : g_chain
      assign ones_below[i]  = ones_below[i-1]  &  q[i-1];
      assign zeros_below[i] = zeros_below[i-1] & ~q[i-1];
   end

   assign at_max  = (q == MAX_Q);
   assign at_zero = (q == '0);
   assign din_ok  = (32'(din) < MODULUS);

   // Per-bit excitation: load > count > hold
   always_comb begin
      j = '0;
      k = '0;
      if (load) begin
         if (din_ok) begin
            j = din;
            k = ~din;
         end else begin
            k = '1;
         end
      end else if (en) begin
         if (up) begin
            if (at_max) begin
               k = '1;
            end else begin
               j = ones_below;
               k = ones_below;
            end
         end else begin
            if (at_zero) begin
               j = MAX_Q;
               k = ~MAX_Q;
            end else begin
               j = zeros_below;
               k = zeros_below;
            end
         end
      end
   end

   // Terminal count is suppressed while held in reset
   assign tc = _reset & en & ~load & ((up & at_max) | (~up & at_zero));

   // Storage bank
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell u_cell (
         .clk    (clk),
         ._reset (_reset),
         .j      (j[i]),
         .k      (k[i]),
         .q      (q[i]),
         ._q     (_q[i])
      );
   end

endmodule : jk_counter

// File: tb/tb_jk_counter.sv
// Directed testbench for jk_counter (WIDTH=4, MODULUS=10).
module tb_jk_counter;

   logic       clk;
   logic       _reset;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] din;
   logic [3:0] q;
   logic [3:0] _q;
   logic       tc;

   int n_checks = 0;
   int n_fail   = 0;

   jk_counter #(.WIDTH(4), .MODULUS(10)) dut (
      .clk    (clk),
      ._reset (_reset),
      .en     (en),
      .up     (up),
      .load   (load),
      .din    (din),
      .q      (q),
      ._q     (_q),
      .tc     (tc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One load cycle, leaving load deasserted afterwards
   task automatic do_load(input logic [3:0] v);
      load = 1'b1;
      din  = v;
      tick();
      load = 1'b0;
      #1;
   endtask

   initial begin
      _reset = 1'b0;
      en     = 1'b1;
      up     = 1'b1;
      load   = 1'b0;
      din    = 4'd0;

      // Held in reset while clocking with en=1
      for (int i = 0; i < 3; i++) begin
         up = (i == 1) ? 1'b0 : 1'b1;
         tick();
         check("rst_q", 32'(q), 32'd0);
         check("rst_nq", 32'(_q), 32'hF);
         check("rst_tc", 32'(tc), 32'd0);
      end
      up = 1'b1;
      _reset = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      check("rel_q3", 32'(q), 32'd3);

      // Up wrap 0..9 -> 0
      en = 1'b0;
      do_load(4'd0);
      en = 1'b1;
      up = 1'b1;
      #1;
      for (int i = 0; i < 10; i++) begin
         check("up_q", 32'(q), 32'(i));
         check("up_nq", 32'(_q), 32'(~i & 4'hF));
         check("up_tc", 32'(tc), (i == 9) ? 32'd1 : 32'd0);
         tick();
      end
      check("up_wrap", 32'(q), 32'd0);

      // Down wrap from 2: 2,1,0,9,8
      do_load(4'd2);
      up = 1'b0;
      #1;
      check("dn_q2", 32'(q), 32'd2);
      check("dn_tc2", 32'(tc), 32'd0);
      tick();
      check("dn_q1", 32'(q), 32'd1);
      check("dn_tc1", 32'(tc), 32'd0);
      tick();
      check("dn_q0", 32'(q), 32'd0);
      check("dn_tc0", 32'(tc), 32'd1);
      tick();
      check("dn_q9", 32'(q), 32'd9);
      check("dn_tc9", 32'(tc), 32'd0);
      tick();
      check("dn_q8", 32'(q), 32'd8);

      // Load priority over en, no tc on load cycle
      up = 1'b1;
      tick();
      check("pre_ld_q9", 32'(q), 32'd9);
      check("pre_ld_tc", 32'(tc), 32'd1);
      load = 1'b1;
      din  = 4'd7;
      #1;
      check("ld_tc", 32'(tc), 32'd0);
      tick();
      check("ld_q7", 32'(q), 32'd7);
      din = 4'd12;
      tick();
      check("ld_oor", 32'(q), 32'd0);
      load = 1'b0;

      // Hold at 4 for 5 edges
      do_load(4'd4);
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_q", 32'(q), 32'd4);
      end

      // Direction flip every cycle
      en = 1'b1;
      up = 1'b1; tick(); check("flip_5a", 32'(q), 32'd5);
      up = 1'b0; tick(); check("flip_4a", 32'(q), 32'd4);
      up = 1'b1; tick(); check("flip_5b", 32'(q), 32'd5);
      up = 1'b0; tick(); check("flip_4b", 32'(q), 32'd4);

      // Asynchronous reset between edges
      do_load(4'd6);
      check("ar_q6", 32'(q), 32'd6);
      en = 1'b1;
      up = 1'b1;
      _reset = 1'b0;
      #1;
      check("ar_q0", 32'(q), 32'd0);
      check("ar_nq", 32'(_q), 32'hF);
      _reset = 1'b1;
      #1;
      check("ar_hold", 32'(q), 32'd0);
      tick();
      check("ar_q1", 32'(q), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule : tb_jk_counter

// File: doc/jk_counter.md
# jk_counter

Synchronous modulo up/down counter that drives a bank of JK storage cells through J/K excitation logic, the driving side of the team's JK flip-flop. Each cycle, the excitation logic computes per-bit J/K commands (hold, set, reset, toggle) from the current state and control inputs. It serves as the standard event/sequence counter for the datapath and control units of the midterm CPU. A terminal-count output allows several instances to cascade into wider counters.

## Interface
- WIDTH, 4: counter width in bits; 2..16.
- MODULUS, 10: count range 0..MODULUS-1; 2 <= MODULUS <= 2^WIDTH.
- clk  input  1  single clock; all state changes on rising edge.
- _reset  input  1  asynchronous, active-low reset; clears the counter immediately on assertion.
- en  input  1  count enable.
- up  input  1  direction; 1 = increment, 0 = decrement; sampled only when counting.
- load  input  1  synchronous parallel load; overrides en.
- din  input  WIDTH  load value.
- q  output  WIDTH  current count.
- _q  output  WIDTH  bitwise complement of q, always consistent with q.
- tc  output  1  terminal count, combinational; high in the cycle whose edge wraps the counter.

## Operation
- Priority on each rising clk: _reset low > load > en > hold.
- Hold (en=0, load=0): every bit gets J=0, K=0; q unchanged.
- Load: bit i gets J=din[i], K=~din[i]. If din >= MODULUS, q loads 0 instead: J=0, K=1 on all bits. No tc is produced on a load cycle.
- Count up (en=1, up=1):
  - q < MODULUS-1: bit i toggles (J=K=1) iff all lower bits are 1 (ripple-free carry-lookahead AND chain).
  - q == MODULUS-1: all bits J=0, K=1; next q = 0.
- Count down (en=1, up=0):
  - q > 0: bit i toggles iff all lower bits are 0.
  - q == 0: bit i gets J=(MODULUS-1)[i], K=~(MODULUS-1)[i]; next q = MODULUS-1.
- tc = en & ~load & ((up & q==MODULUS-1) | (~up & q==0)).
- Direction change mid-sequence takes effect on the next counting edge; no extra cycle.
- When MODULUS = 2^WIDTH, the wrap paths coincide with natural toggle behaviour; output is identical either way.
- q never leaves 0..MODULUS-1 once reset or loaded.

## Timing
- Reset values: q = 0, _q = all ones, tc = 0 while _reset is low.
- Asynchronous clear: q goes to 0 without waiting for clk.
- Release: the first active edge is the first rising clk after _reset goes high. _reset released simultaneously with a rising clk is treated as still asserted for that edge.
- Latency: load or count is visible on q one clock after the sampling edge; tc is valid in the same cycle as its q/en/up/load inputs.
- Control inputs must be stable for setup before the rising edge. The excitation path (AND chain plus wrap compare) is budgeted at worst-case gate delay of WIDTH+4 gate levels at the standard gate delay.
- Reset asserted mid-count: the count is abandoned; after release, counting resumes from 0.

## Structure
- Shared defs file: gate macros with standard delays (AND, OR, NOT, NAND, XOR), plus a macro/constant for the JK command encoding (HOLD, SET, RESET, TOGGLE) used by the excitation logic.
- Sub-module jk_cell: one JK storage bit (clk, _reset, j, k, q, _q) with asynchronous active-low clear. It is instantiated WIDTH times via generate.
- Top level contains only the excitation logic, wrap compares, load mux and tc; no behavioural counting arithmetic (no + or -).

## Test plan
- Reset: hold _reset low while toggling clk with en=1 -> q=0, _q=4'hF, tc=0 throughout. Release, then 3 enabled up edges -> q=3.
- Up wrap (MODULUS=10): count from 0 with en=1, up=1 -> q runs 0..9, tc=1 only while q=9, and the next edge gives q=0.
- Down wrap: load 2, then en=1, up=0 -> q=1, 0, 9, 8. tc is high only in the q=0 cycle.
- Load priority and range: load=1, en=1, din=7 -> q=7, tc=0. Then load din=12 -> q=0.
- Hold and direction flip: en=0 for 5 edges at q=4 -> q stays 4. Then up toggling every cycle with en=1 -> q=5, 4, 5, 4.
- Async reset mid-count: at q=6, pulse _reset low between edges -> q=0 immediately, before the next clk. After release, counting restarts at 1.
